// File: rtl/alu_instr_encoder.sv
// Encodes ALU control requests into RV32I OP / OP-IMM words and writes them into
// instruction memory one at a time, with optional read-back verify.

package alu_instr_encoder_pkg;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_LT   = 4'd3;
    localparam logic [3:0] ALU_LTU  = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_EQ   = 4'd10;
    localparam logic [3:0] ALU_GTE  = 4'd11;
    localparam logic [3:0] ALU_GTEU = 4'd12;
    localparam logic [3:0] ALU_NOP  = 4'd15;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic        is_imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
    } alu_req_t;
endpackage

module alu_instr_encoder
    import alu_instr_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter bit          VERIFY = 1'b1,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_alu_op,
    input  logic              req_is_imm,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [11:0]       req_imm,
    output logic              imem_we,
    output logic              imem_re,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_din,
    input  logic              imem_wready,
    input  logic [31:0]       imem_dout,
    output logic              done_pulse,
    output logic              err_illegal,
    output logic              err_verify,
    output logic              wrapped,
    output logic [ADDR_W-1:0] wr_ptr
);
    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {S_IDLE, S_ENC, S_WRITE, S_VERIFY} state_e;

    state_e            state_q, state_d;
    alu_req_t          req_q, req_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_ready_d, imem_we_d, imem_re_d, err_illegal_d, err_verify_d, wrapped_d;
    logic [ADDR_W-1:0] imem_addr_d, wr_ptr_d;
    logic [31:0]       imem_din_d;

    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        legal;
    logic        is_shift;
    logic [31:0] word;

    // Instruction word built from the captured request
    always_comb begin
        funct3   = 3'b000;
        funct7   = 7'b0000000;
        legal    = 1'b1;
        is_shift = 1'b0;
        word     = 32'h0;
        case (req_q.alu_op)
            ALU_ADD: funct3 = 3'b000;
            ALU_SUB: begin
                funct3 = 3'b000;
                funct7 = 7'b0100000;
                legal  = !req_q.is_imm;
            end
            ALU_SLL: begin
                funct3   = 3'b001;
                is_shift = 1'b1;
            end
            ALU_LT:  funct3 = 3'b010;
            ALU_LTU: funct3 = 3'b011;
            ALU_XOR: funct3 = 3'b100;
            ALU_SRL: begin
                funct3   = 3'b101;
                is_shift = 1'b1;
            end
            ALU_SRA: begin
                funct3   = 3'b101;
                funct7   = 7'b0100000;
                is_shift = 1'b1;
            end
            ALU_OR:  funct3 = 3'b110;
            ALU_AND: funct3 = 3'b111;
            default: legal = 1'b0;
        endcase
        if (!req_q.is_imm)
            word = {funct7, req_q.rs2, req_q.rs1, funct3, req_q.rd, OPC_OP};
        else if (is_shift)
            word = {funct7, req_q.imm[4:0], req_q.rs1, funct3, req_q.rd, OPC_OP_IMM};
        else
            word = {req_q.imm, req_q.rs1, funct3, req_q.rd, OPC_OP_IMM};
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        cnt_d         = cnt_q;
        req_ready_d   = 1'b0;
        imem_we_d     = 1'b0;
        imem_re_d     = 1'b0;
        imem_addr_d   = imem_addr;
        imem_din_d    = imem_din;
        err_illegal_d = 1'b0;
        err_verify_d  = err_verify;
        wrapped_d     = wrapped;
        wr_ptr_d      = wr_ptr;
        done_pulse    = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (base_load) begin
                    wr_ptr_d  = base_addr;
                    wrapped_d = 1'b0;
                end
                if (req_valid && req_ready) begin
                    req_d.alu_op = req_alu_op;
                    req_d.is_imm = req_is_imm;
                    req_d.rd     = req_rd;
                    req_d.rs1    = req_rs1;
                    req_d.rs2    = req_rs2;
                    req_d.imm    = req_imm;
                    req_ready_d  = 1'b0;
                    state_d      = S_ENC;
                end
            end
            S_ENC: begin
                if (legal) begin
                    imem_we_d   = 1'b1;
                    imem_addr_d = wr_ptr;
                    imem_din_d  = word;
                    state_d     = S_WRITE;
                end else begin
                    err_illegal_d = 1'b1;
                    req_ready_d   = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_WRITE: begin
                imem_we_d = 1'b1;
                if (imem_wready) begin
                    imem_we_d = 1'b0;
                    wr_ptr_d  = wr_ptr + ADDR_W'(1);
                    if (wr_ptr == '1)
                        wrapped_d = 1'b1;
                    if (VERIFY) begin
                        imem_re_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = S_VERIFY;
                    end else begin
                        done_pulse  = 1'b1;
                        req_ready_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_VERIFY: begin
                // imem_addr/imem_din still hold the written address and word
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(RD_LAT)) begin
                    done_pulse  = 1'b1;
                    if (imem_dout != imem_din)
                        err_verify_d = 1'b1;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                req_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            req_q       <= '0;
            cnt_q       <= '0;
            req_ready   <= 1'b1;
            imem_we     <= 1'b0;
            imem_re     <= 1'b0;
            imem_addr   <= '0;
            imem_din    <= '0;
            err_illegal <= 1'b0;
            err_verify  <= 1'b0;
            wrapped     <= 1'b0;
            wr_ptr      <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            req_ready   <= req_ready_d;
            imem_we     <= imem_we_d;
            imem_re     <= imem_re_d;
            imem_addr   <= imem_addr_d;
            imem_din    <= imem_din_d;
            err_illegal <= err_illegal_d;
            err_verify  <= err_verify_d;
            wrapped     <= wrapped_d;
            wr_ptr      <= wr_ptr_d;
        end
    end
endmodule
